random_sink_chk: RTL and testbench

//  Parametrised stream sink for bench and on-chip traffic soak tests: consumes a valid/ready

---
 rtl/random_sink_chk.sv | 77 +++++++
 tb/tb_random_sink_chk.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/random_sink_chk.sv
// random_sink_chk: valid/ready stream sink with selectable backpressure, beat capture and counters.
// Define RANDOM_SINK_CHK_CHECK_EN to add an incrementing-sequence data checker (err/err_count).
module random_sink_chk #(
  parameter int          BITS       = 8,
  parameter int          SPEED      = 2,
  parameter logic [31:0] SEED       = 32'h1,
  parameter int          COUNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  output logic                  ready,
  input  logic [BITS-1:0]       data,
  input  logic [1:0]            mode,
  input  logic                  clear,
  output logic [BITS-1:0]       last,
  output logic [COUNT_BITS-1:0] beat_count,
  output logic                  err,
  output logic [COUNT_BITS-1:0] err_count
);
  localparam int PW = (SPEED == 0) ? 1 : SPEED;
  logic [31:0]   lfsr;
  logic [PW-1:0] pcnt;
  logic          accept, grant, pgrant, ready_nx;
  assign accept = valid && ready;
  assign grant  = (SPEED == 0) || (lfsr[PW-1:0] == '0);
  assign pgrant = (SPEED == 0) || (pcnt == '0);
  // A grant on the accepting cycle keeps ready high; otherwise an accept releases it.
  always_comb
    ready_nx = (mode == 2'd0) ? 1'b1 :
               (mode == 2'd1) ? (grant  || (ready && !accept)) :
               (mode == 2'd2) ? (pgrant || (ready && !accept)) : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr       <= SEED;
      pcnt       <= '0;
      ready      <= 1'b0;
      last       <= '0;
      beat_count <= '0;
    end else begin
      lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);
      pcnt  <= pcnt + 1'b1;
      ready <= ready_nx;
      if (clear) begin
        last       <= '0;
        beat_count <= '0;
      end else if (accept) begin
        last <= data;
        if (beat_count != '1) beat_count <= beat_count + 1'b1;
      end
    end
`ifdef RANDOM_SINK_CHK_CHECK_EN
  logic [BITS-1:0] expected;
  // Expected always follows the last beat, so each discontinuity is reported once.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      expected  <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (clear) begin
        expected  <= '0;
        err_count <= '0;
      end else if (accept) begin
        expected <= data + 1'b1;
        if (data != expected) begin
          err <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
    end
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_random_sink_chk.sv
// tb_random_sink_chk: directed bench for random_sink_chk (SPEED=2 main instance, SPEED=3/COUNT_BITS=4 second instance).
module tb_random_sink_chk;
`ifdef RANDOM_SINK_CHK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic valid = 0, clear = 0, ready, err;
  logic [7:0] data = 0, last;
  logic [1:0] mode = 0;
  logic [31:0] beat_count, err_count;
  logic v2 = 0, c2 = 0, r2, e2;
  logic [7:0] d2 = 0, l2;
  logic [1:0] m2 = 3;
  logic [3:0] bc2, ec2;
  int n_chk = 0, n_err = 0, stalls = 0;

  always #5 clk = ~clk;

  random_sink_chk #(.BITS(8), .SPEED(2), .SEED(32'h1), .COUNT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .data(data), .mode(mode),
    .clear(clear), .last(last), .beat_count(beat_count), .err(err), .err_count(err_count));

  random_sink_chk #(.BITS(8), .SPEED(3), .SEED(32'h1), .COUNT_BITS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(v2), .ready(r2), .data(d2), .mode(m2),
    .clear(c2), .last(l2), .beat_count(bc2), .err(e2), .err_count(ec2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one beat on the main instance and returns once it has been accepted.
  task automatic send(input logic [7:0] d, output logic e);
    bit ok = 0;
    valid = 1;
    data  = d;
    e     = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      tick();
      e = err;
    end
  endtask

  initial begin
    logic e;
    int acc, first, prev, gap_bad;
    // 1: reset held with valid asserted
    valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_beats", beat_count, 0);
    chk("rst_last", last, 0);
    chk("rst_errs", err_count, 0);
    rst_n = 1;
    tick();
    valid = 0;
    chk("rel_ready", ready, 1);
    chk("rel_beats", beat_count, 0);
    // 2: mode 0 back-to-back 0..99
    stalls = 0;
    for (int i = 0; i < 100; i++) send(8'(i), e);
    valid = 0;
    chk("m0_stalls", stalls, 0);
    chk("m0_beats", beat_count, 100);
    chk("m0_last", last, 99);
    chk("m0_errs", err_count, 0);
    // 3: mode 1 random backpressure, 1000 beats continuing the sequence
    mode = 1;
    stalls = 0;
    for (int i = 100; i < 1100; i++) send(8'(i), e);
    valid = 0;
    chk("m1_beats", beat_count, 1100);
    chk("m1_last", last, 8'(1099));
    chk("m1_errs", err_count, 0);
    chk("m1_duty", 32'((stalls >= 667) && (stalls <= 5667)), 1);
    // clear resets capture and checker state
    mode = 0;
    clear = 1;
    tick();
    clear = 0;
    chk("clr_beats", beat_count, 0);
    chk("clr_last", last, 0);
    // 5: one discontinuity (2 -> 5), then a clean 255 -> 0 wrap
    send(0, e); send(1, e); send(2, e);
    send(5, e);
    chk("gap_err", e, CHK);
    send(6, e);
    chk("gap_pulse", e, 0);
    for (int i = 7; i < 256; i++) send(8'(i), e);
    send(0, e);
    valid = 0;
    chk("wrap_err", e, 0);
    chk("seq_errs", err_count, CHK ? 1 : 0);
    chk("seq_beats", beat_count, 255);
    chk("seq_last", last, 0);
    // 6: saturation on the 4-bit instance
    c2 = 1; tick(); c2 = 0;
    m2 = 0; tick();
    v2 = 1;
    repeat (20) tick();
    v2 = 0;
    chk("sat_beats", bc2, 15);
    v2 = 1; c2 = 1; d2 = 8'h5a;
    @(negedge clk);
    chk("clr_acc_ready", r2, 1);
    tick();
    c2 = 0; v2 = 0;
    chk("clr_acc_beats", bc2, 0);
    chk("clr_acc_last", l2, 0);
    v2 = 1;
    repeat (3) tick();
    m2 = 3;
    tick();
    chk("stall_ready", r2, 0);
    chk("stall_edge_beat", bc2, 4);
    repeat (10) tick();
    v2 = 0;
    chk("stall_beats", bc2, 4);
    chk("stall_ready_hold", r2, 0);
    // 4: periodic mode, SPEED=3 -> one accept every 8 cycles
    c2 = 1; tick(); c2 = 0;
    m2 = 2; v2 = 1;
    repeat (16) tick();
    acc = 0; first = -1; prev = -1; gap_bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (v2 && r2) begin
        if (prev >= 0 && c - prev != 8) gap_bad++;
        prev = c;
        acc++;
      end
    end
    v2 = 0;
    chk("per_accepts", acc, 8);
    chk("per_gap", gap_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
